sha3_padder: RTL

- Upstream feeder for the Keccak absorb/permute stage.
- Accepts a message as a stream of 64-bit little-endian words and packs them into rate-sized blocks laid out as the 5x5x64 Keccak state. Capacity lanes are always zero.
- Applies SHA-3 multi-rate padding: the domain byte goes after the last message byte, and 0x80 is ORed into the last rate byte.
- Presents each block with valid/ready and a last-block flag, ready to be XOR-absorbed by the permutation stage.

---
 rtl/sha3_padder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sha3_padder.sv
// sha3_padder: packs a little-endian 64-bit word stream into Keccak rate
// blocks and applies SHA-3 multi-rate padding (domain byte after the message
// and 0x80 in the last rate byte).
//
// Ports:
//   clk, nrst               clock, asynchronous active-low reset
//   xof_sel                 (only with SHA3_PAD_SHAKE_EN) 1 selects the SHAKE domain byte 0x1F
//   in_data/in_nbytes/in_last/in_valid/in_ready   message word stream
//   blk_data/blk_last/blk_valid/blk_ready         5x5 lane block out, rate lane i at [i%5][i/5]
//
// Optional feature macro: SHA3_PAD_SHAKE_EN
//
// state | meaning
// FILL  | accepting message words into the lane buffer
// PAD   | message ended on a word boundary; write domain byte into lane widx
// EMIT  | block presented on blk_*, waiting for blk_ready
module sha3_padder #(
  parameter int         WIDTH      = 64,
  parameter int         RATE_WORDS = 17,
  parameter logic [7:0] DSBYTE     = 8'h06
) (
  input  logic                         clk,
  input  logic                         nrst,
`ifdef SHA3_PAD_SHAKE_EN
  input  logic                         xof_sel,
`endif
  input  logic [WIDTH-1:0]             in_data,
  input  logic [3:0]                   in_nbytes,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [0:4][0:4][WIDTH-1:0]   blk_data,
  output logic                         blk_last,
  output logic                         blk_valid,
  input  logic                         blk_ready
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_WORDS - 1);

  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

  state_t           state;
  logic [4:0]       widx;
  logic             pad_pend;
  logic [7:0]       ds_q;
  logic [WIDTH-1:0] lane_q [RATE_WORDS];

  logic [7:0]       cur_ds;
  logic [3:0]       nb;
  logic [WIDTH-1:0] byte_mask;
  logic [WIDTH-1:0] ds_word;
  logic [WIDTH-1:0] wr_word;
  logic             accept;

`ifdef SHA3_PAD_SHAKE_EN
  assign cur_ds = xof_sel ? 8'h1F : DSBYTE;
`else
  assign cur_ds = DSBYTE;
`endif

  assign accept = in_valid && in_ready;
  // Byte counts above 8 behave as a full word.
  assign nb     = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;

  always_comb begin
    byte_mask = '1;
    if (nb != 4'd8)
      byte_mask = (WIDTH'(1) << {nb, 3'b000}) - WIDTH'(1);
    ds_word = {{(WIDTH-8){1'b0}}, cur_ds} << {nb[2:0], 3'b000};
    wr_word = in_data & byte_mask;
    if (in_last && nb != 4'd8)
      wr_word = wr_word | ds_word;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= FILL;
      widx      <= '0;
      pad_pend  <= 1'b0;
      ds_q      <= DSBYTE;
      in_ready  <= 1'b0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      for (int i = 0; i < RATE_WORDS; i++) lane_q[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            lane_q[widx] <= wr_word;
            if (in_last) ds_q <= cur_ds;
            if (!in_last) begin
              if (widx == LAST_IDX) begin
                state     <= EMIT;
                in_ready  <= 1'b0;
                blk_valid <= 1'b1;
                blk_last  <= 1'b0;
              end else begin
                widx <= widx + 5'd1;
              end
            end else if (nb != 4'd8) begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              blk_valid <= 1'b1;
              blk_last  <= 1'b1;
            end else if (widx != LAST_IDX) begin
              widx     <= widx + 5'd1;
              state    <= PAD;
              in_ready <= 1'b0;
            end else begin
              // Full last block: the padding needs a block of its own.
              pad_pend  <= 1'b1;
              state     <= EMIT;
              in_ready  <= 1'b0;
              blk_valid <= 1'b1;
              blk_last  <= 1'b0;
            end
          end
        end
        PAD: begin
          in_ready     <= 1'b0;
          lane_q[widx] <= lane_q[widx] | {{(WIDTH-8){1'b0}}, ds_q};
          state        <= EMIT;
          blk_valid    <= 1'b1;
          blk_last     <= 1'b1;
        end
        EMIT: begin
          in_ready <= 1'b0;
          if (blk_ready) begin
            for (int i = 0; i < RATE_WORDS; i++) lane_q[i] <= '0;
            widx      <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            if (pad_pend) begin
              pad_pend <= 1'b0;
              state    <= PAD;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Lane layout plus the final 0x80 pad bit, applied only on the last block.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < RATE_WORDS; i++)
      blk_data[3'(i % 5)][3'(i / 5)] = lane_q[i];
    if (blk_last)
      blk_data[3'((RATE_WORDS-1) % 5)][3'((RATE_WORDS-1) / 5)][WIDTH-1 -: 8] =
        lane_q[RATE_WORDS-1][WIDTH-1 -: 8] | 8'h80;
  end

endmodule
